iob_merge: RTL and testbench

IOB_MERGE -- requirements
Module: iob_merge

---
 rtl/iob_merge.sv | 129 ++++++++++++
 tb/tb_iob_merge.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_merge.sv
// iob_merge: round-robin merge of N_MASTERS request/response ports onto one
// slave port. One transaction is in flight at a time. The winning request
// payload is captured so the slave sees a stable request while BUSY.
module iob_merge #(
    parameter int N_MASTERS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    localparam int STRB_W   = DATA_W / 8,
    localparam int REQ_W    = 1 + ADDR_W + DATA_W + STRB_W,
    localparam int RESP_W   = DATA_W + 1,
    localparam int SEL_W    = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_MASTERS*REQ_W-1:0]  m_req,
    output logic [N_MASTERS*RESP_W-1:0] m_resp,
    output logic [REQ_W-1:0]            s_req,
    input  logic [RESP_W-1:0]           s_resp
);

    localparam int PAY_W = REQ_W - 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [SEL_W-1:0]    r_sel;
    logic [SEL_W-1:0]    r_ptr;
    logic [PAY_W-1:0]    r_hold;

    logic [N_MASTERS-1:0] w_valid;
    logic [PAY_W-1:0]     w_pay [N_MASTERS];
    logic [SEL_W-1:0]     w_grant;
    logic                 w_any;
    logic                 w_load;
    logic                 w_done;
    logic                 w_ready;
    logic [DATA_W-1:0]    w_rdata;

    assign w_rdata = s_resp[RESP_W-1:1];
    // Slave ready only means something while a transaction is in flight.
    assign w_ready = (r_state == BUSY) && s_resp[0];

    // Unpack master request slices and fan the response back out.
    // rdata is broadcast; ready goes only to the master being served.
    generate
        for (genvar gi = 0; gi < N_MASTERS; gi++) begin : g_port
            assign w_valid[gi] = m_req[gi*REQ_W + REQ_W - 1];
            assign w_pay[gi]   = m_req[gi*REQ_W +: PAY_W];
            assign m_resp[gi*RESP_W +: RESP_W] =
                {w_rdata, w_ready && (r_sel == SEL_W'(gi))};
        end
    endgenerate

    // Round-robin search starting after ptr. Scanning from the farthest
    // candidate down to ptr+1 lets the nearest valid index overwrite the
    // others, which gives first-valid-wins without an early exit.
    always_comb begin
        int idx;
        w_grant = r_ptr;
        w_any   = 1'b0;
        idx     = 0;
        for (int i = N_MASTERS; i >= 1; i--) begin
            idx = int'(r_ptr) + i;
            if (idx >= N_MASTERS) begin
                idx = idx - N_MASTERS;
            end
            if (w_valid[idx[SEL_W-1:0]]) begin
                w_any   = 1'b1;
                w_grant = idx[SEL_W-1:0];
            end
        end
    end

    // Next-state logic: grant from IDLE, complete on slave ready in BUSY.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_next = BUSY;
                    w_load       = 1'b1;
                end
            end
            BUSY: begin
                if (w_ready) begin
                    w_state_next = IDLE;
                    w_done       = 1'b1;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // State register; reset drops any in-flight transaction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Capture the winner on grant; advance the priority pointer on completion.
    // ptr resets to the last index so master 0 has first priority.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sel  <= '0;
            r_ptr  <= SEL_W'(N_MASTERS - 1);
            r_hold <= '0;
        end else begin
            if (w_load) begin
                r_hold <= w_pay[w_grant];
                r_sel  <= w_grant;
            end
            if (w_done) begin
                r_ptr <= r_sel;
            end
        end
    end

    assign s_req = (r_state == BUSY) ? {1'b1, r_hold} : '0;

endmodule

// File: tb/tb_iob_merge.sv
// Scoreboard bench for iob_merge: an N=2 instance for most scenarios and an
// N=3 instance for pointer wrap. Expected completions are queued by the
// stimulus; negedge monitors check each master ready pulse against the queue.
module tb_iob_merge;

    localparam int REQ_W  = 69;
    localparam int RESP_W = 33;

    typedef struct {
        int          m;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] rdata;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic [2*REQ_W-1:0]  m_req_a  = '0;
    logic [2*RESP_W-1:0] m_resp_a;
    logic [REQ_W-1:0]    s_req_a;
    logic [RESP_W-1:0]   s_resp_a = '0;
    logic [3*REQ_W-1:0]  m_req_b  = '0;
    logic [3*RESP_W-1:0] m_resp_b;
    logic [REQ_W-1:0]    s_req_b;
    logic [RESP_W-1:0]   s_resp_b = '0;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   r_cyc   = 0;
    exp_t qa[$];
    exp_t qb[$];

    iob_merge #(.N_MASTERS(2), .ADDR_W(32), .DATA_W(32)) u_dut_a (
        .clk(clk), .rst(rst), .m_req(m_req_a), .m_resp(m_resp_a),
        .s_req(s_req_a), .s_resp(s_resp_a)
    );

    iob_merge #(.N_MASTERS(3), .ADDR_W(32), .DATA_W(32)) u_dut_b (
        .clk(clk), .rst(rst), .m_req(m_req_b), .m_resp(m_resp_b),
        .s_req(s_req_b), .s_resp(s_resp_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end else begin
            $display("[TB] ok %s = %0h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input int k, input logic v, input logic [31:0] ad,
                         input logic [31:0] wd, input logic [3:0] ws);
        m_req_a[k*REQ_W +: REQ_W] = {v, ad, wd, ws};
    endtask

    task automatic set_b(input int k, input logic v, input logic [31:0] ad,
                         input logic [31:0] wd, input logic [3:0] ws);
        m_req_b[k*REQ_W +: REQ_W] = {v, ad, wd, ws};
    endtask

    function automatic exp_t mk(input int m, input logic [31:0] ad, input logic [31:0] wd,
                                input logic [3:0] ws, input logic [31:0] rd);
        exp_t e;
        e.m = m; e.addr = ad; e.wdata = wd; e.wstrb = ws; e.rdata = rd;
        return e;
    endfunction

    // Slave model: wait (bounded) for s_req valid, hold d cycles, pulse ready.
    task automatic serve(input int which, input int d, input logic [31:0] rd);
        int   n = 0;
        logic v;
        v = (which == 0) ? s_req_a[REQ_W-1] : s_req_b[REQ_W-1];
        while (!v && n < 20) begin
            tick();
            n++;
            v = (which == 0) ? s_req_a[REQ_W-1] : s_req_b[REQ_W-1];
        end
        if (!v) chk("serve_wait_valid", 64'(v), 64'd1);
        repeat (d) tick();
        if (which == 0) s_resp_a = {rd, 1'b1};
        else            s_resp_b = {rd, 1'b1};
        r_cyc = cyc;
        tick();
        if (which == 0) s_resp_a = {rd, 1'b0};
        else            s_resp_b = {rd, 1'b0};
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    // Monitor for the N=2 instance.
    always @(negedge clk) begin
        logic [1:0] rv;
        exp_t       e;
        rv = {m_resp_a[RESP_W], m_resp_a[0]};
        if (rv != 2'b00) begin
            if (qa.size() == 0) begin
                chk("a_unexpected_ready", 64'(rv), 64'd0);
            end else begin
                e = qa.pop_front();
                chk("a_grant", 64'(rv), 64'(1) << e.m);
                for (int k = 0; k < 2; k++)
                    chk("a_rdata", 64'(m_resp_a[k*RESP_W+1 +: 32]), 64'(e.rdata));
                chk("a_addr",  64'(s_req_a[67:36]), 64'(e.addr));
                chk("a_wdata", 64'(s_req_a[35:4]),  64'(e.wdata));
                chk("a_wstrb", 64'(s_req_a[3:0]),   64'(e.wstrb));
            end
        end
    end

    // Monitor for the N=3 instance.
    always @(negedge clk) begin
        logic [2:0] rv;
        exp_t       e;
        rv = {m_resp_b[2*RESP_W], m_resp_b[RESP_W], m_resp_b[0]};
        if (rv != 3'b000) begin
            if (qb.size() == 0) begin
                chk("b_unexpected_ready", 64'(rv), 64'd0);
            end else begin
                e = qb.pop_front();
                chk("b_grant", 64'(rv), 64'(1) << e.m);
                chk("b_rdata", 64'(m_resp_b[e.m*RESP_W+1 +: 32]), 64'(e.rdata));
                chk("b_addr",  64'(s_req_b[67:36]), 64'(e.addr));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rc_prev;

        // Reset state
        tick();
        tick();
        chk("rst_s_req_a", 64'(s_req_a), 64'd0);
        chk("rst_s_req_b", 64'(s_req_b), 64'd0);
        chk("rst_ready_a", 64'({m_resp_a[RESP_W], m_resp_a[0]}), 64'd0);
        rst = 1'b1;
        tick();
        chk("idle_s_req_a", 64'(s_req_a), 64'd0);

        // Single read on master 0, slave answers 3 cycles after the request
        set_a(0, 1'b1, 32'h10, 32'h0, 4'h0);
        chk("single_valid_c", 64'(s_req_a[REQ_W-1]), 64'd0);
        tick();
        chk("single_valid_c1", 64'(s_req_a[REQ_W-1]), 64'd1);
        chk("single_addr_c1", 64'(s_req_a[67:36]), 64'h10);
        qa.push_back(mk(0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF));
        serve(0, 2, 32'hDEADBEEF);
        set_a(0, 1'b0, 32'h0, 32'h0, 4'h0);
        chk("single_valid_c4", 64'(s_req_a[REQ_W-1]), 64'd0);

        // Contention from reset: expect 0,1,0,1 with one bubble between
        do_reset();
        set_a(0, 1'b1, 32'h100, 32'hA0, 4'hF);
        set_a(1, 1'b1, 32'h104, 32'hA1, 4'hF);
        rc_prev = 0;
        for (int i = 0; i < 4; i++) begin
            qa.push_back(mk(i % 2, (i % 2) ? 32'h104 : 32'h100,
                            (i % 2) ? 32'hA1 : 32'hA0, 4'hF, 32'h1000 + i));
            serve(0, 1, 32'h1000 + i);
            chk("cont_bubble", 64'(s_req_a[REQ_W-1]), 64'd0);
            if (i > 0) chk("cont_gap", 64'(r_cyc - rc_prev), 64'd3);
            rc_prev = r_cyc;
        end
        set_a(0, 1'b0, 32'h0, 32'h0, 4'h0);
        set_a(1, 1'b0, 32'h0, 32'h0, 4'h0);

        // Request stability: master 1 write changes payload while BUSY
        set_a(1, 1'b1, 32'h20, 32'h12345678, 4'h3);
        qa.push_back(mk(1, 32'h20, 32'h12345678, 4'h3, 32'hCAFEF00D));
        tick();
        set_a(1, 1'b1, 32'h20, 32'h0, 4'h0);
        tick();
        chk("stab_wdata", 64'(s_req_a[35:4]), 64'h12345678);
        chk("stab_wstrb", 64'(s_req_a[3:0]), 64'h3);
        serve(0, 1, 32'hCAFEF00D);
        set_a(1, 1'b0, 32'h0, 32'h0, 4'h0);

        // Spurious slave ready while IDLE
        s_resp_a = {32'h55, 1'b1};
        #1;
        chk("spur_ready", 64'({m_resp_a[RESP_W], m_resp_a[0]}), 64'd0);
        tick();
        chk("spur_idle", 64'(s_req_a[REQ_W-1]), 64'd0);
        chk("spur_ready2", 64'({m_resp_a[RESP_W], m_resp_a[0]}), 64'd0);
        s_resp_a = '0;

        // Reset mid-transaction: leave ptr at 0 first so m1 would otherwise win
        set_a(0, 1'b1, 32'h30, 32'h0, 4'h0);
        qa.push_back(mk(0, 32'h30, 32'h0, 4'h0, 32'h77));
        serve(0, 1, 32'h77);
        set_a(0, 1'b0, 32'h0, 32'h0, 4'h0);
        set_a(1, 1'b1, 32'h40, 32'h0, 4'h0);
        tick();
        chk("abort_busy", 64'(s_req_a[REQ_W-1]), 64'd1);
        @(posedge clk);
        #3 rst = 1'b0;
        #1 chk("abort_s_req", 64'(s_req_a), 64'd0);
        set_a(1, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();
        rst = 1'b1;
        s_resp_a = {32'h99, 1'b1};
        #1;
        chk("abort_late_ready", 64'({m_resp_a[RESP_W], m_resp_a[0]}), 64'd0);
        tick();
        s_resp_a = '0;
        chk("abort_idle", 64'(s_req_a[REQ_W-1]), 64'd0);
        set_a(0, 1'b1, 32'h50, 32'h0, 4'h0);
        set_a(1, 1'b1, 32'h54, 32'h0, 4'h0);
        qa.push_back(mk(0, 32'h50, 32'h0, 4'h0, 32'h11));
        qa.push_back(mk(1, 32'h54, 32'h0, 4'h0, 32'h12));
        serve(0, 1, 32'h11);
        set_a(0, 1'b0, 32'h0, 32'h0, 4'h0);
        serve(0, 1, 32'h12);
        set_a(1, 1'b0, 32'h0, 32'h0, 4'h0);

        // Wrap with N=3: serve m2, then m0 and m1 together
        set_b(2, 1'b1, 32'h200, 32'h0, 4'h0);
        qb.push_back(mk(2, 32'h200, 32'h0, 4'h0, 32'h22));
        serve(1, 1, 32'h22);
        set_b(2, 1'b0, 32'h0, 32'h0, 4'h0);
        set_b(0, 1'b1, 32'h300, 32'h0, 4'h0);
        set_b(1, 1'b1, 32'h304, 32'h0, 4'h0);
        qb.push_back(mk(0, 32'h300, 32'h0, 4'h0, 32'h33));
        qb.push_back(mk(1, 32'h304, 32'h0, 4'h0, 32'h44));
        serve(1, 1, 32'h33);
        set_b(0, 1'b0, 32'h0, 32'h0, 4'h0);
        serve(1, 1, 32'h44);
        set_b(1, 1'b0, 32'h0, 32'h0, 4'h0);

        tick();
        tick();
        chk("qa_drained", 64'(qa.size()), 64'd0);
        chk("qb_drained", 64'(qb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
